mc_control: RTL and testbench



---
 rtl/mc_control.sv | 241 ++++++++++++++++++++++++
 tb/tb_mc_control.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// mc_control: multi-cycle MIPS main control unit.
// Walks each instruction through FETCH/DECODE/EXEC/(MULW)/MEM/WB, with a TRAP
// state for illegal opcodes, writes to $0 and data-memory timeouts.
// Optional feature macro: MC_CONTROL_MUL_EN enables the multi-cycle mul opcode
// (0x1c) together with the MULW state and its counter.
module mc_control #(
    parameter int MUL_CYCLES  = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [5:0]  opcode,
    input  logic        dest_zero,
    input  logic        mem_ready,
    input  logic        exc_ack,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        mem_req,
    output logic        mem_we,
    output logic        reg_write,
    output logic [10:0] control_signal,
    output logic        exception,
    output logic [1:0]  exc_cause,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MULW   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_MUL   = 6'h1c;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_ZERO_WR = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

    // Timeout counter holds "MEM cycles already spent"; it must be able to
    // represent MEM_TIMEOUT itself.
    localparam int             MCW       = $clog2(MEM_TIMEOUT + 1);
    localparam logic [MCW-1:0] MEM_LIMIT = MCW'(MEM_TIMEOUT);
    localparam bit             MUL_MULTI = (MUL_CYCLES > 1);

    state_t         state_q, state_d;
    logic [5:0]     opcode_q, opcode_d;
    logic [10:0]    ctrl_q, ctrl_d;
    logic           exc_q, exc_d;
    logic [1:0]     cause_q, cause_d;
    logic [MCW-1:0] mem_cnt_q, mem_cnt_d;
    logic [MCW-1:0] mem_elapsed;
    logic [10:0]    dec_word;
    logic           is_mul;

`ifdef MC_CONTROL_MUL_EN
    // MULW lasts MUL_CYCLES-1 cycles: counter runs 0 .. MUL_CYCLES-2.
    localparam logic [3:0] MUL_LAST = 4'((MUL_CYCLES > 1) ? (MUL_CYCLES - 2) : 0);
    logic [3:0] mul_cnt_q, mul_cnt_d;
    assign is_mul = (opcode_q == OP_MUL);
`else
    assign is_mul = 1'b0;
`endif

    // Opcode to control word:
    // [10] jump [9] branch [8] mem_read [7] mem_write [6] mem_to_reg
    // [5:4] alu_op/size [3] illegal [2] alu_src [1] reg_write [0] reg_dst
    function automatic logic [10:0] decode_op(input logic [5:0] op);
        logic [10:0] w;
        case (op)
            OP_RTYPE:       w = 11'b00000100011;
`ifdef MC_CONTROL_MUL_EN
            OP_MUL:         w = 11'b00000100011;
`endif
            OP_J:           w = 11'b10000010000;
            OP_BEQ, OP_BNE: w = 11'b01000010000;
            OP_LW:          w = 11'b00101000110;
            OP_LH:          w = 11'b00101110110;
            OP_SW:          w = 11'b00010000100;
            OP_SH:          w = 11'b00010110100;
            OP_ADDI:        w = 11'b00000000110;
            default:        w = 11'b00000001000;
        endcase
        return w;
    endfunction

    assign dec_word = decode_op(opcode_q);

    // Next-state, control word, trap flag and counter updates.
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        ctrl_d      = ctrl_q;
        exc_d       = exc_q;
        cause_d     = cause_q;
        mem_cnt_d   = '0;
        mem_elapsed = mem_cnt_q + MCW'(1);
`ifdef MC_CONTROL_MUL_EN
        mul_cnt_d   = '0;
`endif
        case (state_q)
            S_FETCH: begin
                if (instr_valid) begin
                    opcode_d = opcode;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                ctrl_d = dec_word;
                if (opcode_q == OP_J) begin
                    state_d = S_FETCH;
                end else if (dec_word[3]) begin
                    state_d = S_TRAP;
                    exc_d   = 1'b1;
                    cause_d = CAUSE_ILLEGAL;
                end else if (dec_word[1] && dest_zero) begin
                    state_d = S_TRAP;
                    exc_d   = 1'b1;
                    cause_d = CAUSE_ZERO_WR;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (ctrl_q[9]) begin
                    state_d = S_FETCH;
                end else if (ctrl_q[8] || ctrl_q[7]) begin
                    state_d = S_MEM;
                end else if (is_mul && MUL_MULTI) begin
                    state_d = S_MULW;
                end else begin
                    state_d = S_WB;
                end
            end
`ifdef MC_CONTROL_MUL_EN
            S_MULW: begin
                if (mul_cnt_q == MUL_LAST) begin
                    state_d = S_WB;
                end else begin
                    mul_cnt_d = mul_cnt_q + 4'd1;
                end
            end
`endif
            S_MEM: begin
                // A response in the cycle the count reaches the limit still wins.
                if (mem_ready) begin
                    state_d = ctrl_q[7] ? S_FETCH : S_WB;
                end else if (mem_elapsed == MEM_LIMIT) begin
                    state_d = S_TRAP;
                    exc_d   = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    mem_cnt_d = mem_elapsed;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
            end
            S_TRAP: begin
                if (exc_ack) begin
                    state_d = S_FETCH;
                    exc_d   = 1'b0;
                    cause_d = CAUSE_NONE;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Per-state strobes decoded from the state register.
    always_comb begin
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        reg_write     = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write = instr_valid;
                pc_write = instr_valid;
            end
            S_DECODE: pc_write      = (opcode_q == OP_J);
            S_EXEC:   pc_write_cond = ctrl_q[9];
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = ctrl_q[7];
            end
            S_WB:     reg_write     = 1'b1;
            default: ;
        endcase
    end

    // State and registered outputs; reset returns everything to FETCH/zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            opcode_q  <= '0;
            ctrl_q    <= '0;
            exc_q     <= 1'b0;
            cause_q   <= CAUSE_NONE;
            mem_cnt_q <= '0;
`ifdef MC_CONTROL_MUL_EN
            mul_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            ctrl_q    <= ctrl_d;
            exc_q     <= exc_d;
            cause_q   <= cause_d;
            mem_cnt_q <= mem_cnt_d;
`ifdef MC_CONTROL_MUL_EN
            mul_cnt_q <= mul_cnt_d;
`endif
        end
    end

    assign control_signal = ctrl_q;
    assign exception      = exc_q;
    assign exc_cause      = cause_q;
    assign state          = state_q;

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: builds an expected per-cycle trace from instruction-level
// rules (phase lists per instruction class), drives it, and compares.
module tb_mc_control;

    localparam int MUL_CYCLES  = 4;
    localparam int MEM_TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [5:0]  opcode;
    logic        dest_zero;
    logic        mem_ready;
    logic        exc_ack;
    logic        ir_write;
    logic        pc_write;
    logic        pc_write_cond;
    logic        mem_req;
    logic        mem_we;
    logic        reg_write;
    logic [10:0] control_signal;
    logic        exception;
    logic [1:0]  exc_cause;
    logic [2:0]  state;

    always #5 clk = ~clk;

    mc_control #(.MUL_CYCLES(MUL_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode),
        .dest_zero(dest_zero), .mem_ready(mem_ready), .exc_ack(exc_ack),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .mem_req(mem_req), .mem_we(mem_we), .reg_write(reg_write),
        .control_signal(control_signal), .exception(exception),
        .exc_cause(exc_cause), .state(state)
    );

    // One entry per clock cycle: inputs to drive and outputs expected.
    // strb order: {ir_write, pc_write, pc_write_cond, mem_req, mem_we, reg_write}
    typedef struct packed {
        logic        chk;
        logic        rst;
        logic        iv;
        logic [5:0]  op;
        logic        dz;
        logic        mr;
        logic        ack;
        logic [2:0]  st;
        logic [5:0]  strb;
        logic [10:0] cw;
        logic        exc;
        logic [1:0]  cause;
    } cyc_t;

    cyc_t        tr[$];
    logic [10:0] model_cw;
    int          total = 0;
    int          bad   = 0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] ro();
        return 6'($urandom_range(0, 63));
    endfunction

    // Reference control words straight from the opcode table.
    function automatic logic [10:0] exp_word(input logic [5:0] op);
        case (op)
            6'h00: return 11'b00000100011;
`ifdef MC_CONTROL_MUL_EN
            6'h1c: return 11'b00000100011;
`endif
            6'h02: return 11'b10000010000;
            6'h04, 6'h05: return 11'b01000010000;
            6'h23: return 11'b00101000110;
            6'h21: return 11'b00101110110;
            6'h2b: return 11'b00010000100;
            6'h29: return 11'b00010110100;
            6'h08: return 11'b00000000110;
            default: return 11'b00000001000;
        endcase
    endfunction

    function automatic bit mul_enabled();
`ifdef MC_CONTROL_MUL_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic push(input logic r, input logic iv, input logic [5:0] op,
                        input logic dz, input logic mr, input logic ack,
                        input logic [2:0] st, input logic [5:0] strb,
                        input logic exc, input logic [1:0] cause);
        cyc_t c;
        c.chk = 1'b1; c.rst = r; c.iv = iv; c.op = op; c.dz = dz; c.mr = mr;
        c.ack = ack; c.st = st; c.strb = strb; c.cw = model_cw;
        c.exc = exc; c.cause = cause;
        tr.push_back(c);
    endtask

    // Trap: stay in state 6 for `hold` cycles without ack, then one acked cycle.
    task automatic gen_trap(input logic [1:0] cause, input int hold);
        for (int i = 0; i < hold; i++)
            push(1'b0, rb(), ro(), rb(), rb(), 1'b0, 3'd6, 6'b0, 1'b1, cause);
        push(1'b0, rb(), ro(), rb(), rb(), 1'b1, 3'd6, 6'b0, 1'b1, cause);
    endtask

    // One instruction: idle cycles, then the phase list its class implies.
    // mem_wait = MEM cycles spent without mem_ready before it arrives.
    task automatic gen_instr(input logic [5:0] op, input logic dz, input int mem_wait,
                             input int idle, input int hold);
        logic [10:0] w;
        int          n;
        bit          ok;
        for (int i = 0; i < idle; i++)
            push(1'b0, 1'b0, ro(), rb(), rb(), rb(), 3'd0, 6'b0, 1'b0, 2'd0);
        push(1'b0, 1'b1, op, rb(), rb(), rb(), 3'd0, 6'b110000, 1'b0, 2'd0);
        w = exp_word(op);
        push(1'b0, rb(), ro(), dz, rb(), rb(), 3'd1,
             (op == 6'h02) ? 6'b010000 : 6'b000000, 1'b0, 2'd0);
        model_cw = w;
        if (op == 6'h02) return;
        if (w[3]) begin gen_trap(2'd1, hold); return; end
        if (w[1] && dz) begin gen_trap(2'd2, hold); return; end
        if (w[9]) begin
            push(1'b0, rb(), ro(), rb(), rb(), rb(), 3'd2, 6'b001000, 1'b0, 2'd0);
            return;
        end
        push(1'b0, rb(), ro(), rb(), rb(), rb(), 3'd2, 6'b000000, 1'b0, 2'd0);
        if (w[8] || w[7]) begin
            ok = (mem_wait + 1 <= MEM_TIMEOUT);
            n  = ok ? mem_wait + 1 : MEM_TIMEOUT;
            for (int i = 0; i < n; i++)
                push(1'b0, rb(), ro(), rb(), ok && (i == n - 1), rb(), 3'd4,
                     {3'b000, 1'b1, w[7], 1'b0}, 1'b0, 2'd0);
            if (!ok) gen_trap(2'd3, hold);
            else if (w[8]) push(1'b0, rb(), ro(), rb(), rb(), rb(), 3'd5, 6'b000001, 1'b0, 2'd0);
            return;
        end
        if (mul_enabled() && op == 6'h1c)
            for (int i = 0; i < MUL_CYCLES - 1; i++)
                push(1'b0, rb(), ro(), rb(), rb(), rb(), 3'd3, 6'b0, 1'b0, 2'd0);
        push(1'b0, rb(), ro(), rb(), rb(), rb(), 3'd5, 6'b000001, 1'b0, 2'd0);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    logic [5:0] ops [11] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h1c,
                             6'h21, 6'h23, 6'h29, 6'h2b, 6'h3f};

    initial begin
        cyc_t c;
        logic [5:0] op;
        rst = 1'b1; instr_valid = 1'b0; opcode = '0; dest_zero = 1'b0;
        mem_ready = 1'b0; exc_ack = 1'b0;
        model_cw = '0;

        // Reset cycle (outputs unknown before the first edge), then idle.
        c = '0; c.rst = 1'b1; tr.push_back(c);
        push(1'b1, 1'b0, ro(), rb(), rb(), rb(), 3'd0, 6'b0, 1'b0, 2'd0);
        push(1'b0, 1'b0, ro(), rb(), rb(), rb(), 3'd0, 6'b0, 1'b0, 2'd0);

        // Directed cases.
        gen_instr(6'h00, 1'b0, 0, 0, 0);        // R-format
        gen_instr(6'h23, 1'b0, 2, 0, 0);        // lw, ready on 3rd MEM cycle
        gen_instr(6'h2b, 1'b0, 99, 0, 2);       // sw, bus timeout
        gen_instr(6'h23, 1'b0, MEM_TIMEOUT - 1, 1, 0); // ready on the last allowed cycle
        gen_instr(6'h3f, 1'b0, 0, 0, 1);        // illegal opcode
        gen_instr(6'h08, 1'b1, 0, 0, 0);        // addi to $0
        gen_instr(6'h1c, 1'b0, 0, 0, 0);        // mul (or illegal)
        gen_instr(6'h04, 1'b0, 0, 2, 0);        // beq
        gen_instr(6'h29, 1'b0, 0, 0, 0);        // sh, immediate ready

        // Reset while in MEM, then a jump.
        push(1'b0, 1'b1, 6'h23, rb(), rb(), rb(), 3'd0, 6'b110000, 1'b0, 2'd0);
        push(1'b0, rb(), ro(), 1'b0, rb(), rb(), 3'd1, 6'b0, 1'b0, 2'd0);
        model_cw = exp_word(6'h23);
        push(1'b0, rb(), ro(), rb(), rb(), rb(), 3'd2, 6'b0, 1'b0, 2'd0);
        push(1'b0, rb(), ro(), rb(), 1'b0, rb(), 3'd4, 6'b000100, 1'b0, 2'd0);
        push(1'b1, rb(), ro(), rb(), 1'b0, rb(), 3'd4, 6'b000100, 1'b0, 2'd0);
        model_cw = '0;
        push(1'b0, 1'b0, ro(), rb(), rb(), rb(), 3'd0, 6'b0, 1'b0, 2'd0);
        gen_instr(6'h02, 1'b0, 0, 0, 0);

        // Randomized instruction stream.
        for (int k = 0; k < 60; k++) begin
            op = ($urandom_range(0, 7) == 0) ? ro() : ops[$urandom_range(0, 10)];
            gen_instr(op, ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 5) == 0) ? int'($urandom_range(13, 17))
                                                  : int'($urandom_range(0, 4)),
                      $urandom_range(0, 2), $urandom_range(0, 3));
        end
        push(1'b0, 1'b0, ro(), rb(), rb(), rb(), 3'd0, 6'b0, 1'b0, 2'd0);

        foreach (tr[k]) begin
            @(negedge clk);
            rst = tr[k].rst; instr_valid = tr[k].iv; opcode = tr[k].op;
            dest_zero = tr[k].dz; mem_ready = tr[k].mr; exc_ack = tr[k].ack;
            #1;
            if (tr[k].chk) begin
                chk($sformatf("state@%0d", k), 16'(state), 16'(tr[k].st));
                chk($sformatf("strobes@%0d", k),
                    16'({ir_write, pc_write, pc_write_cond, mem_req, mem_we, reg_write}),
                    16'(tr[k].strb));
                chk($sformatf("control_signal@%0d", k), 16'(control_signal), 16'(tr[k].cw));
                chk($sformatf("exception@%0d", k), 16'({exception, exc_cause}),
                    16'({tr[k].exc, tr[k].cause}));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
